// File: rtl/vga_pkg.sv
// Shared constants for the VGA pattern controller: active area, pattern
// encoding and the RGB565 colour palette.
package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  typedef enum logic [1:0] {
    PAT_BARS = 2'd0,
    PAT_GRID = 2'd1,
    PAT_GRAD = 2'd2,
    PAT_BOX  = 2'd3
  } pattern_t;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t WHITE   = 16'hFFFF;
  localparam rgb565_t YELLOW  = 16'hFFE0;
  localparam rgb565_t CYAN    = 16'h07FF;
  localparam rgb565_t GREEN   = 16'h07E0;
  localparam rgb565_t MAGENTA = 16'hF81F;
  localparam rgb565_t RED     = 16'hF800;
  localparam rgb565_t BLUE    = 16'h001F;
  localparam rgb565_t BLACK   = 16'h0000;

  function automatic pattern_t next_pat(input pattern_t p);
    case (p)
      PAT_BARS: next_pat = PAT_GRID;
      PAT_GRID: next_pat = PAT_GRAD;
      PAT_GRAD: next_pat = PAT_BOX;
      default:  next_pat = PAT_BARS;
    endcase
  endfunction

  // Classic colour-bar order, brightest first
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = WHITE;
      3'd1:    bar_colour = YELLOW;
      3'd2:    bar_colour = CYAN;
      3'd3:    bar_colour = GREEN;
      3'd4:    bar_colour = MAGENTA;
      3'd5:    bar_colour = RED;
      3'd6:    bar_colour = BLUE;
      default: bar_colour = BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pattern_ctrl_if.sv
// Signal bundle between the sync generator side and the pattern controller.
interface vga_pattern_ctrl_if;

  logic        hsync_in;
  logic        vsync_in;
  logic        ready;
  logic [10:0] column_addr_sig;
  logic [10:0] row_addr_sig;
  logic        next_pattern;
  logic        hsync_out;
  logic        vsync_out;
  logic [4:0]  red_sig;
  logic [5:0]  green_sig;
  logic [4:0]  blue_sig;
  logic [1:0]  pattern_sel;

  modport master (
    output hsync_in, vsync_in, ready, column_addr_sig, row_addr_sig, next_pattern,
    input  hsync_out, vsync_out, red_sig, green_sig, blue_sig, pattern_sel
  );

  modport slave (
    input  hsync_in, vsync_in, ready, column_addr_sig, row_addr_sig, next_pattern,
    output hsync_out, vsync_out, red_sig, green_sig, blue_sig, pattern_sel
  );

endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker; moves one step per frame and reflects off
// the edges of the visible area.
module vga_box_mover #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP  = 11'(BOX_STEP);

  logic dir_x;
  logic dir_y;
  logic [11:0] next_x;
  logic [11:0] next_y;

  // Returns {new_dir, new_pos}; the decreasing test compares before
  // subtracting so the position can never wrap below zero.
  function automatic logic [11:0] bounce(input logic [10:0] pos, input logic dir,
                                         input logic [10:0] lim);
    if (dir) begin
      if (pos + STEP >= lim) bounce = {1'b0, lim};
      else                   bounce = {1'b1, pos + STEP};
    end else begin
      if (pos <= STEP)       bounce = {1'b1, 11'd0};
      else                   bounce = {1'b0, pos - STEP};
    end
  endfunction

  assign next_x = bounce(box_x, dir_x, X_MAX);
  assign next_y = bounce(box_y, dir_y, Y_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      box_x <= '0;
      box_y <= '0;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
    end else if (step) begin
      {dir_x, box_x} <= next_x;
      {dir_y, box_y} <= next_y;
    end
  end

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Test-pattern generator behind the VGA sync generator: two-stage pixel
// pipeline, frame-synchronous pattern sequencer and RGB565 colour mux.
module vga_pattern_ctrl #(
  parameter int H_ACTIVE           = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE           = vga_pkg::V_ACTIVE,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BOX_SIZE           = 64,
  parameter int BOX_STEP           = 4,
  parameter bit SYNC_ACTIVE_LOW    = 1'b0
) (
  input logic               clk,
  input logic               rst,
  vga_pattern_ctrl_if.slave bus
);

  import vga_pkg::*;

  localparam int          BAR_W    = H_ACTIVE / 8;
  localparam int          CW       = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAMES_PER_PATTERN - 1);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] BOX_LEN  = 11'(BOX_SIZE);
  localparam logic        INACTIVE = SYNC_ACTIVE_LOW;

  pattern_t      state;
  logic [CW-1:0] frame_cnt;
  logic          pending;
  logic [10:0]   box_x;
  logic [10:0]   box_y;

  logic          ready_s1, hs_s1, vs_s1, vs_s1_d;
  logic          in_range_s1, grid_s1, box_s1;
  logic [2:0]    bar_s1;
  logic [4:0]    grad_r_s1;
  logic [5:0]    grad_g_s1;

  logic [2:0]    bar_idx;
  logic          grid_hit, box_hit, in_range;
  logic [4:0]    grad_r;
  logic [5:0]    grad_g;
  logic          frame_start;

  rgb565_t       pixel_next;
  rgb565_t       pixel_s2;
  logic          hs_s2, vs_s2;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box (
    .clk   (clk),
    .rst   (rst),
    .step  (frame_start),
    .box_x (box_x),
    .box_y (box_y)
  );

  // Region decode for stage 1; bar index is a threshold chain, not a divide
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bus.column_addr_sig >= 11'(i * BAR_W)) bar_idx = 3'(i);
    end
    grid_hit = (bus.column_addr_sig[4:0] == 5'd0) || (bus.row_addr_sig[4:0] == 5'd0) ||
               (bus.column_addr_sig == H_LAST)    || (bus.row_addr_sig == V_LAST);
    box_hit  = (bus.column_addr_sig >= box_x) && (bus.column_addr_sig < box_x + BOX_LEN) &&
               (bus.row_addr_sig >= box_y)    && (bus.row_addr_sig < box_y + BOX_LEN);
    in_range = (bus.column_addr_sig < 11'(H_ACTIVE)) && (bus.row_addr_sig < 11'(V_ACTIVE));
    grad_r   = bus.column_addr_sig[10] ? 5'h1F : bus.column_addr_sig[9:5];
    grad_g   = bus.row_addr_sig[10]    ? 6'h3F : bus.row_addr_sig[9:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_s1    <= 1'b0;
      hs_s1       <= INACTIVE;
      vs_s1       <= INACTIVE;
      vs_s1_d     <= INACTIVE;
      in_range_s1 <= 1'b0;
      grid_s1     <= 1'b0;
      box_s1      <= 1'b0;
      bar_s1      <= 3'd0;
      grad_r_s1   <= 5'd0;
      grad_g_s1   <= 6'd0;
    end else begin
      ready_s1    <= bus.ready;
      hs_s1       <= bus.hsync_in;
      vs_s1       <= bus.vsync_in;
      vs_s1_d     <= vs_s1;
      in_range_s1 <= in_range;
      grid_s1     <= grid_hit;
      box_s1      <= box_hit;
      bar_s1      <= bar_idx;
      grad_r_s1   <= grad_r;
      grad_g_s1   <= grad_g;
    end
  end

  assign frame_start = (vs_s1 != INACTIVE) && (vs_s1_d == INACTIVE);

  // A request that lands on a frame start is parked for the following frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PAT_BARS;
      frame_cnt <= '0;
      pending   <= 1'b0;
    end else if (frame_start) begin
      if (pending || (frame_cnt == CNT_MAX)) begin
        state     <= next_pat(state);
        frame_cnt <= '0;
        pending   <= bus.next_pattern;
      end else begin
        frame_cnt <= frame_cnt + CW'(1);
        pending   <= pending | bus.next_pattern;
      end
    end else if (bus.next_pattern) begin
      pending <= 1'b1;
    end
  end

  always_comb begin
    pixel_next = BLACK;
    if (ready_s1 && in_range_s1) begin
      case (state)
        PAT_BARS: pixel_next = bar_colour(bar_s1);
        PAT_GRID: pixel_next = grid_s1 ? WHITE : BLACK;
        PAT_GRAD: pixel_next = {grad_r_s1, grad_g_s1, 5'd0};
        default:  pixel_next = box_s1 ? WHITE : BLUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_s2 <= BLACK;
      hs_s2    <= INACTIVE;
      vs_s2    <= INACTIVE;
    end else begin
      pixel_s2 <= pixel_next;
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
    end
  end

  assign bus.red_sig     = pixel_s2[15:11];
  assign bus.green_sig   = pixel_s2[10:5];
  assign bus.blue_sig    = pixel_s2[4:0];
  assign bus.hsync_out   = hs_s2;
  assign bus.vsync_out   = vs_s2;
  assign bus.pattern_sel = state;

endmodule

// File: tb/tb_vga_pattern_ctrl.sv
// Directed bench for vga_pattern_ctrl: colour bars, latency, pattern
// sequencing, box bounce and mid-frame reset.
module tb_vga_pattern_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vga_pattern_ctrl_if bus();

  vga_pattern_ctrl #(
    .FRAMES_PER_PATTERN (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rgb();
    rgb = {bus.red_sig, bus.green_sig, bus.blue_sig};
  endfunction

  task automatic applyStimulus(input logic rdy, input int col, input int row);
    bus.ready           = rdy;
    bus.column_addr_sig = 11'(col);
    bus.row_addr_sig    = 11'(row);
  endtask

  task automatic show_pixel(input int col, input int row);
    applyStimulus(1'b1, col, row);
    repeat (2) @(negedge clk);
  endtask

  // Short synthetic frame: two cycles of active vsync then two idle
  task automatic run_frame(input bit coincident);
    bus.vsync_in = 1'b1;
    @(negedge clk);
    if (coincident) bus.next_pattern = 1'b1;
    @(negedge clk);
    bus.next_pattern = 1'b0;
    bus.vsync_in     = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.hsync_in     = 1'b0;
    bus.vsync_in     = 1'b0;
    bus.next_pattern = 1'b0;
    applyStimulus(1'b0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rgb() !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 0000", rgb()); end
    checks++; if (bus.hsync_out !== 1'b0 || bus.vsync_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync: got %b%b expected 00", bus.hsync_out, bus.vsync_out); end
    checks++; if (bus.pattern_sel !== 2'd0) begin errors++; $display("[TB] FAIL reset_pattern: got %0d expected 0", bus.pattern_sel); end
    checks++; if (dut.u_box.box_x !== 11'd0 || dut.u_box.box_y !== 11'd0) begin errors++; $display("[TB] FAIL reset_box: got (%0d,%0d) expected (0,0)", dut.u_box.box_x, dut.u_box.box_y); end
  endtask

  task automatic test_bars();
    int          cols [6] = '{0, 99, 100, 450, 650, 799};
    logic [15:0] exp  [6] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hF81F, 16'h001F, 16'h0000};
    for (int i = 0; i < 6; i++) begin
      show_pixel(cols[i], 10);
      checks++;
      if (rgb() !== exp[i]) begin errors++; $display("[TB] FAIL bars_col%0d: got %h expected %h", cols[i], rgb(), exp[i]); end
    end
  endtask

  task automatic test_blanking();
    show_pixel(0, 10);
    applyStimulus(1'b0, 0, 10);
    bus.hsync_in = 1'b1;
    @(negedge clk);
    checks++; if (rgb() !== 16'hFFFF || bus.hsync_out !== 1'b0) begin errors++; $display("[TB] FAIL blank_n1: got %h/%b expected ffff/0", rgb(), bus.hsync_out); end
    @(negedge clk);
    checks++; if (rgb() !== 16'h0000 || bus.hsync_out !== 1'b1) begin errors++; $display("[TB] FAIL blank_n2: got %h/%b expected 0000/1", rgb(), bus.hsync_out); end
    applyStimulus(1'b1, 0, 10);
    bus.hsync_in = 1'b0;
    @(negedge clk);
    checks++; if (rgb() !== 16'h0000 || bus.hsync_out !== 1'b1) begin errors++; $display("[TB] FAIL unblank_n1: got %h/%b expected 0000/1", rgb(), bus.hsync_out); end
    @(negedge clk);
    checks++; if (rgb() !== 16'hFFFF || bus.hsync_out !== 1'b0) begin errors++; $display("[TB] FAIL unblank_n2: got %h/%b expected ffff/0", rgb(), bus.hsync_out); end
  endtask

  task automatic test_auto_advance();
    logic [1:0] exp [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_frame(1'b0);
      checks++;
      if (bus.pattern_sel !== exp[k]) begin errors++; $display("[TB] FAIL auto_frame%0d: got %0d expected %0d", k + 1, bus.pattern_sel, exp[k]); end
    end
  endtask

  task automatic test_manual_advance();
    int          gc [6] = '{32, 33, 33, 799, 800, 0};
    int          gr [6] = '{5, 5, 599, 7, 0, 600};
    logic [15:0] ge [6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    do_reset();
    run_frame(1'b0);
    run_frame(1'b0);
    checks++; if (bus.pattern_sel !== 2'd1) begin errors++; $display("[TB] FAIL manual_grid: got %0d expected 1", bus.pattern_sel); end
    for (int i = 0; i < 6; i++) begin
      show_pixel(gc[i], gr[i]);
      checks++;
      if (rgb() !== ge[i]) begin errors++; $display("[TB] FAIL grid_%0d_%0d: got %h expected %h", gc[i], gr[i], rgb(), ge[i]); end
    end
    applyStimulus(1'b1, 10, 300);
    bus.next_pattern = 1'b1;
    @(negedge clk);
    bus.next_pattern = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.pattern_sel !== 2'd1) begin errors++; $display("[TB] FAIL manual_midframe: got %0d expected 1", bus.pattern_sel); end
    run_frame(1'b0);
    checks++; if (bus.pattern_sel !== 2'd2) begin errors++; $display("[TB] FAIL manual_grad: got %0d expected 2", bus.pattern_sel); end
    show_pixel(799, 599);
    checks++; if (rgb() !== 16'hC4A0) begin errors++; $display("[TB] FAIL grad_799_599: got %h expected c4a0", rgb()); end
    show_pixel(160, 32);
    checks++; if (rgb() !== 16'h2840) begin errors++; $display("[TB] FAIL grad_160_32: got %h expected 2840", rgb()); end
    run_frame(1'b1);
    checks++; if (bus.pattern_sel !== 2'd2) begin errors++; $display("[TB] FAIL coincident_hold: got %0d expected 2", bus.pattern_sel); end
    run_frame(1'b0);
    checks++; if (bus.pattern_sel !== 2'd3) begin errors++; $display("[TB] FAIL coincident_apply: got %0d expected 3", bus.pattern_sel); end
    run_frame(1'b0);
    checks++; if (bus.pattern_sel !== 2'd3) begin errors++; $display("[TB] FAIL pending_cleared: got %0d expected 3", bus.pattern_sel); end
  endtask

  task automatic test_bounce();
    logic [10:0] ex [3] = '{11'd732, 11'd736, 11'd732};
    logic [10:0] ey [3] = '{11'd4, 11'd0, 11'd4};
    do_reset();
    repeat (182) run_frame(1'b0);
    checks++; if (dut.u_box.box_x !== 11'd728) begin errors++; $display("[TB] FAIL box_x_182: got %0d expected 728", dut.u_box.box_x); end
    for (int i = 0; i < 3; i++) begin
      run_frame(1'b0);
      checks++;
      if (dut.u_box.box_x !== ex[i]) begin errors++; $display("[TB] FAIL box_x_%0d: got %0d expected %0d", 183 + i, dut.u_box.box_x, ex[i]); end
    end
    repeat (82) run_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) run_frame(1'b0);
      checks++;
      if (dut.u_box.box_y !== ey[i]) begin errors++; $display("[TB] FAIL box_y_%0d: got %0d expected %0d", 267 + i, dut.u_box.box_y, ey[i]); end
    end
    run_frame(1'b0);
    checks++; if (bus.pattern_sel !== 2'd3) begin errors++; $display("[TB] FAIL box_pattern: got %0d expected 3", bus.pattern_sel); end
    show_pixel(392, 8);
    checks++; if (rgb() !== 16'hFFFF) begin errors++; $display("[TB] FAIL box_corner: got %h expected ffff", rgb()); end
    show_pixel(455, 71);
    checks++; if (rgb() !== 16'hFFFF) begin errors++; $display("[TB] FAIL box_far_corner: got %h expected ffff", rgb()); end
    show_pixel(456, 8);
    checks++; if (rgb() !== 16'h001F) begin errors++; $display("[TB] FAIL box_right_edge: got %h expected 001f", rgb()); end
    show_pixel(391, 40);
    checks++; if (rgb() !== 16'h001F) begin errors++; $display("[TB] FAIL box_left_edge: got %h expected 001f", rgb()); end
  endtask

  task automatic test_mid_frame_reset();
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    show_pixel(400, 40);
    checks++; if (rgb() !== 16'hFFFF || bus.hsync_out !== 1'b1 || bus.vsync_out !== 1'b1) begin errors++; $display("[TB] FAIL prereset: got %h/%b%b expected ffff/11", rgb(), bus.hsync_out, bus.vsync_out); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rgb() !== 16'h0000 || bus.pattern_sel !== 2'd0) begin errors++; $display("[TB] FAIL midreset_out: got %h/%0d expected 0000/0", rgb(), bus.pattern_sel); end
    checks++; if (bus.hsync_out !== 1'b0 || bus.vsync_out !== 1'b0) begin errors++; $display("[TB] FAIL midreset_sync: got %b%b expected 00", bus.hsync_out, bus.vsync_out); end
    checks++; if (dut.u_box.box_x !== 11'd0 || dut.u_box.box_y !== 11'd0) begin errors++; $display("[TB] FAIL midreset_box: got (%0d,%0d) expected (0,0)", dut.u_box.box_x, dut.u_box.box_y); end
    repeat (2) @(negedge clk);
    checks++; if (rgb() !== 16'hF81F || bus.hsync_out !== 1'b1) begin errors++; $display("[TB] FAIL postreset: got %h/%b expected f81f/1", rgb(), bus.hsync_out); end
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
  endtask

  initial begin
    $display("[TB] starting vga_pattern_ctrl bench");
    test_reset();
    test_bars();
    test_blanking();
    test_auto_advance();
    test_manual_advance();
    test_bounce();
    test_mid_frame_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
